// File: rtl/dac_map_pkg.sv
// Shared encodings for the DAC symbol mapper: modulation modes, Gray level table, underrun idle limit.
package dac_map_pkg;

   typedef enum logic [1:0] {
      MODE_BPSK  = 2'd0,
      MODE_QPSK  = 2'd1,
      MODE_16QAM = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_e;

   localparam int UNDERRUN_IDLE_SLOTS = 16;

   // Level multiplier for one rail; bpr = 1 uses bits[0] only, bpr = 2 is Gray coded.
   function automatic logic signed [2:0] map_level(input logic [1:0] bits, input logic [1:0] bpr);
      logic signed [2:0] lvl;
      if (bpr == 2'd1) begin
         lvl = bits[0] ? -3'sd1 : 3'sd1;
      end else begin
         case (bits)
            2'b00:   lvl = 3'sd3;
            2'b01:   lvl = 3'sd1;
            2'b11:   lvl = -3'sd1;
            default: lvl = -3'sd3;
         endcase
      end
      return lvl;
   endfunction

endpackage

// File: rtl/dac_symbol_mapper_if.sv
// Code-word input stream and I/Q DAC sample output of the symbol mapper.
interface dac_symbol_mapper_if #(
   parameter int DAC_W = 14
);
   logic [15:0]             in_i;
   logic [15:0]             in_q;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [DAC_W-1:0] dac_i;
   logic signed [DAC_W-1:0] dac_q;
   logic                    dac_valid;

   modport slave (
      input  in_i, in_q, in_valid,
      output in_ready, dac_i, dac_q, dac_valid
   );

   modport master (
      output in_i, in_q, in_valid,
      input  in_ready, dac_i, dac_q, dac_valid
   );
endinterface

// File: rtl/sync_fifo_iq.sv
// Synchronous FIFO for I/Q code-word pairs; simultaneous push and pop both take effect.
// Full flag is registered from the next-state count, so pushes while full are dropped, never overwritten.
module sync_fifo_iq #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_pop_dat,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_cnt;
   logic [AW:0]      w_cnt_nxt;
   logic             r_full;
   logic             w_push;
   logic             w_pop;

   assign o_empty   = (r_cnt == '0);
   assign o_full    = r_full;
   assign o_pop_dat = r_mem[r_rd_ptr];
   assign w_push    = i_push && !r_full;
   assign w_pop     = i_pop && !o_empty;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_push && !w_pop) begin
         w_cnt_nxt = r_cnt + 1'b1;
      end else if (!w_push && w_pop) begin
         w_cnt_nxt = r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_full   <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_full <= (w_cnt_nxt == FULL_CNT);
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
   end

endmodule

// File: rtl/dac_symbol_mapper.sv
// Serialises buffered I/Q code words MSB-first into BPSK/QPSK/16QAM symbols, each held SPS clocks on the DAC.
// First sample two edges after an accept into an idle block; in_ready falls only when the word FIFO is full.
module dac_symbol_mapper
   import dac_map_pkg::*;
#(
   parameter int DAC_W      = 14,
   parameter int AMP        = 2047,
   parameter int SPS        = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [1:0]         mode,
   dac_symbol_mapper_if.slave bus,
   output logic [15:0]        underrun_cnt,
   output logic               busy
);
   localparam int HOLD_W = (SPS > 1) ? $clog2(SPS) : 1;
   localparam logic [HOLD_W-1:0]       HOLD_LAST = HOLD_W'(SPS - 1);
   localparam logic signed [DAC_W-1:0] A1 = DAC_W'(AMP);
   localparam logic signed [DAC_W-1:0] A3 = DAC_W'(3 * AMP);

   logic [31:0]             w_pop_dat;
   logic                    w_fifo_full;
   logic                    w_fifo_empty;
   logic [15:0]             r_shift_i;
   logic [15:0]             r_shift_q;
   logic [4:0]              r_sym_left;
   logic                    r_qam;
   logic                    r_bpsk;
   logic [HOLD_W-1:0]       r_hold;
   logic                    r_active;
   logic [4:0]              r_idle_slots;
   logic [15:0]             r_underrun_cnt;
   logic signed [DAC_W-1:0] r_dac_i;
   logic signed [DAC_W-1:0] r_dac_q;
   logic                    r_dac_valid;
   logic signed [DAC_W-1:0] w_smp_i;
   logic signed [DAC_W-1:0] w_smp_q;
   logic                    w_shift_vld;
   logic                    w_last_hold;
   logic                    w_load;
   logic                    w_slot_underrun;
   logic [1:0]              w_bpr;
   logic [1:0]              w_bits_i;
   logic [1:0]              w_bits_q;

   function automatic logic signed [DAC_W-1:0] lvl_to_smp(input logic signed [2:0] lvl);
      logic signed [DAC_W-1:0] smp;
      case (lvl)
         3'sd3:   smp = A3;
         3'sd1:   smp = A1;
         -3'sd1:  smp = -A1;
         -3'sd3:  smp = -A3;
         default: smp = '0;
      endcase
      return smp;
   endfunction

   sync_fifo_iq #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (bus.in_valid),
      .i_push_dat ({bus.in_i, bus.in_q}),
      .i_pop      (w_load),
      .o_pop_dat  (w_pop_dat),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty)
   );

   assign w_shift_vld     = (r_sym_left != 5'd0);
   assign w_last_hold     = (r_hold == HOLD_LAST);
   // Reload on the final hold cycle of the last symbol keeps back-to-back words gap-free.
   assign w_load          = enable && !w_fifo_empty &&
                            (!w_shift_vld || (r_sym_left == 5'd1 && w_last_hold));
   assign w_slot_underrun = enable && r_active && !w_shift_vld && w_fifo_empty && (r_hold == '0);

   assign w_bpr    = r_qam ? 2'd2 : 2'd1;
   assign w_bits_i = r_qam ? r_shift_i[15:14] : {1'b0, r_shift_i[15]};
   assign w_bits_q = r_qam ? r_shift_q[15:14] : {1'b0, r_shift_q[15]};
   assign w_smp_i  = lvl_to_smp(map_level(w_bits_i, w_bpr));
   assign w_smp_q  = lvl_to_smp(map_level(w_bits_q, w_bpr));

   assign bus.in_ready  = !w_fifo_full;
   assign bus.dac_i     = r_dac_i;
   assign bus.dac_q     = r_dac_q;
   assign bus.dac_valid = r_dac_valid;
   assign underrun_cnt  = r_underrun_cnt;
   assign busy          = !w_fifo_empty || w_shift_vld;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_shift_i      <= '0;
         r_shift_q      <= '0;
         r_sym_left     <= '0;
         r_qam          <= 1'b0;
         r_bpsk         <= 1'b0;
         r_hold         <= '0;
         r_active       <= 1'b0;
         r_idle_slots   <= '0;
         r_underrun_cnt <= '0;
         r_dac_i        <= '0;
         r_dac_q        <= '0;
         r_dac_valid    <= 1'b0;
      end else begin
         if (enable && w_shift_vld) begin
            r_dac_i     <= w_smp_i;
            r_dac_q     <= r_bpsk ? '0 : w_smp_q;
            r_dac_valid <= 1'b1;
         end else begin
            r_dac_i     <= '0;
            r_dac_q     <= '0;
            r_dac_valid <= 1'b0;
         end

         if (w_load) begin
            r_shift_i    <= w_pop_dat[31:16];
            r_shift_q    <= w_pop_dat[15:0];
            r_qam        <= (mode == MODE_16QAM);
            r_bpsk       <= (mode == MODE_BPSK);
            r_sym_left   <= (mode == MODE_16QAM) ? 5'd8 : 5'd16;
            r_hold       <= '0;
            r_active     <= 1'b1;
            r_idle_slots <= '0;
         end else if (!enable) begin
            // Paused: bit position is kept, the symbol restarts its full hold on resume.
            r_hold <= '0;
         end else if (w_shift_vld) begin
            if (w_last_hold) begin
               r_shift_i  <= r_qam ? {r_shift_i[13:0], 2'b00} : {r_shift_i[14:0], 1'b0};
               r_shift_q  <= r_qam ? {r_shift_q[13:0], 2'b00} : {r_shift_q[14:0], 1'b0};
               r_sym_left <= r_sym_left - 5'd1;
               r_hold     <= '0;
            end else begin
               r_hold <= r_hold + 1'b1;
            end
         end else if (r_active) begin
            r_hold <= w_last_hold ? '0 : r_hold + 1'b1;
            if (w_slot_underrun) begin
               if (r_underrun_cnt != 16'hFFFF) r_underrun_cnt <= r_underrun_cnt + 16'd1;
               if (r_idle_slots == 5'(UNDERRUN_IDLE_SLOTS - 1)) begin
                  r_active     <= 1'b0;
                  r_idle_slots <= '0;
                  r_hold       <= '0;
               end else begin
                  r_idle_slots <= r_idle_slots + 5'd1;
               end
            end
         end
      end
   end

endmodule
